flash_region_loader: RTL and testbench
======================================

// Module: flash_region_loader
// PURPOSE
//  Boot-time copier: streams up to NUM_REGIONS flash regions (NEXTOR, FM-BIOS, PAC, MEGAROM...)
//  into their SD-RAM windows before the cartridge is released to the MSX bus. It generalises the
//  fixed NEXTOR+FM-BIOS copy to a parametrised region table with a run-time enable mask,
//  odd-length tails and byte-stream backpressure. It sits between the SPI-flash reader and the
//  SD-RAM arbiter write port.
// PARAMETERS
//  NUM_REGIONS  3         number of table entries (1..8)
//  REGION_SRC   {24'h10_0000,24'h12_0000,24'h1F_0000}  packed [NUM_REGIONS*24-1:0], flash byte addr; entry 0 = LSBs
//  REGION_DST   {24'h70_0000,24'h72_0000,24'h77_E000}  packed, SD-RAM byte addr; must be even
//  REGION_SIZE  {24'h02_0000,24'h00_4000,24'h00_2000}  packed, byte count; 0 = entry skipped
//  AUTO_START   1         1: run once automatically after reset release
// PORTS
//  clk             in   1   system clock
//  reset_n         in   1   async active-low reset
//  start           in   1   pulse; starts a run when idle (ignored while busy)
//  region_en       in   NUM_REGIONS  per-entry enable, sampled per entry in SELECT
//  busy            out  1   run in progress
//  done            out  1   high from end of run until next start/reset
//  cur_region      out  3   entry being copied
//  flash_req       out  1   1-cycle pulse: open burst at flash_addr
//  flash_addr      out  24  burst start address
//  flash_stop      out  1   1-cycle pulse: close burst
//  flash_valid     in   1   byte available
//  flash_data      in   8   byte
//  flash_ready     out  1   byte consumed when valid&ready
//  ram_wr_req      out  1   write request, held until ack
//  ram_addr        out  24  SD-RAM byte address, always even
//  ram_data        out  16  {hi byte, lo byte}; little-endian
//  ram_be          out  2   byte enables
//  ram_wr_ack      in   1   write accepted this cycle
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE. Reset mid-run aborts at once; no flash_stop is issued
//    (the flash reader is reset from the same reset_n).
//  - States: IDLE -> SELECT -> OPEN -> LO -> HI -> WRITE -> (LO | CLOSE) ; CLOSE -> SELECT ; SELECT -> DONE.
//  - IDLE: start (or first cycle after reset when AUTO_START=1) -> SELECT, busy=1, done=0, idx=0.
//  - SELECT: if idx==NUM_REGIONS -> DONE. If !region_en[idx] or SIZE==0: idx++ and stay in SELECT
//    (one cycle per skipped entry). Otherwise load remaining count and the byte offset off=0 -> OPEN.
//  - OPEN: flash_req=1 for one cycle, flash_addr=SRC[idx] -> LO.
//  - LO: flash_ready=1; on handshake latch the low byte and decrement remaining.
//    If remaining becomes 0 -> WRITE with be=2'b01, else -> HI.
//  - HI: on handshake latch the high byte, be=2'b11 -> WRITE. flash_ready=0 in WRITE/OPEN/CLOSE.
//  - WRITE: ram_wr_req=1, ram_addr=DST[idx]+off; addr/data/be stable until ram_wr_ack.
//    On ack: off+=2; remaining==0 -> CLOSE, else -> LO.
//  - CLOSE: flash_stop=1 for one cycle; idx++ -> SELECT.
//  - DONE: busy=0, done=1 -> IDLE (done held). A start in IDLE clears done.
//  - Counters are 24 bit; DST+off wraps mod 2^24 (not checked). At most one write outstanding.
//  - cur_region = idx while busy; 0 otherwise.
//  - Throughput bound: 1 byte per cycle from flash, one word per SD-RAM ack.
// STRUCTURE
//  - Typedef state_t and a region_t struct {src,dst,size}, each 24 bit, in package CONFIG.
//  - Table slicing function get_region(idx) in CONFIG, shared with the PAC save logic.
//  - Single module; no sub-modules; the datapath (byte packer + counters) stays inline.
// TESTING
//  1. AUTO_START=1, all enabled, small sizes 4/2/6: exactly 6 writes; first write addr 70_0000,
//     data {b1,b0}, be=11; then done=1.
//  2. region_en=3'b101: entry 1 is never opened; there are exactly 2 flash_req/flash_stop pairs
//     and cur_region sequence is 0,2.
//  3. SIZE=3: 2 writes; the second has addr=DST+2, be=2'b01 and data[7:0]=byte2; flash_stop
//     follows the ack.
//  4. ram_wr_ack delayed 5 cycles and flash_valid toggling: ram_* are stable while req=1, and
//     flash_ready=0 during WRITE; no byte is lost or duplicated when compared against the model.
//  5. reset_n low in the middle of region 1: all outputs are 0 next cycle; with AUTO_START a
//     full rerun is fully correct.
//  6. start pulsed while busy: ignored; start after done: done falls, a second identical run
//     follows.

Source files
------------

// File: rtl/flash_region_loader_pkg.sv
// ============================================================================
// Module : flash_region_loader_pkg
// Brief  : Region table types and slicing helper for the boot-time copier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package flash_region_loader_pkg;

   localparam int MAX_REGIONS = 8;
   localparam int ADDR_W      = 24;
   localparam int TBL_W       = MAX_REGIONS * ADDR_W;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_OPEN   = 3'd2,
      ST_LO     = 3'd3,
      ST_HI     = 3'd4,
      ST_WRITE  = 3'd5,
      ST_CLOSE  = 3'd6,
      ST_DONE   = 3'd7
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] src;
      logic [ADDR_W-1:0] dst;
      logic [ADDR_W-1:0] size;
   } region_t;

   // Tables are zero-padded to MAX_REGIONS entries; entry 0 sits in the LSBs.
   function automatic region_t get_region(input logic [TBL_W-1:0] src_tbl,
                                          input logic [TBL_W-1:0] dst_tbl,
                                          input logic [TBL_W-1:0] size_tbl,
                                          input logic [2:0]       idx);
      region_t r;
      r.src  = src_tbl[idx*ADDR_W +: ADDR_W];
      r.dst  = dst_tbl[idx*ADDR_W +: ADDR_W];
      r.size = size_tbl[idx*ADDR_W +: ADDR_W];
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/flash_region_loader.sv
// ============================================================================
// Module : flash_region_loader
// Brief  : Copies enabled flash regions into SD-RAM as little-endian words.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module flash_region_loader
   import flash_region_loader_pkg::*;
#(
   parameter int                        NUM_REGIONS = 3,
   parameter logic [NUM_REGIONS*24-1:0] REGION_SRC  = {24'h10_0000, 24'h12_0000, 24'h1F_0000},
   parameter logic [NUM_REGIONS*24-1:0] REGION_DST  = {24'h70_0000, 24'h72_0000, 24'h77_E000},
   parameter logic [NUM_REGIONS*24-1:0] REGION_SIZE = {24'h02_0000, 24'h00_4000, 24'h00_2000},
   parameter bit                        AUTO_START  = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [NUM_REGIONS-1:0] region_en,
   output logic                   busy,
   output logic                   done,
   output logic [2:0]             cur_region,
   output logic                   flash_req,
   output logic [23:0]            flash_addr,
   output logic                   flash_stop,
   input  logic                   flash_valid,
   input  logic [7:0]             flash_data,
   output logic                   flash_ready,
   output logic                   ram_wr_req,
   output logic [23:0]            ram_addr,
   output logic [15:0]            ram_data,
   output logic [1:0]             ram_be,
   input  logic                   ram_wr_ack
);

   localparam logic [TBL_W-1:0] SRC_TBL  = TBL_W'(REGION_SRC);
   localparam logic [TBL_W-1:0] DST_TBL  = TBL_W'(REGION_DST);
   localparam logic [TBL_W-1:0] SIZE_TBL = TBL_W'(REGION_SIZE);

   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [23:0] rem_q, rem_d;
   logic [23:0] off_q, off_d;
   logic [7:0]  lo_q, lo_d;
   logic [7:0]  hi_q, hi_d;
   logic [1:0]  be_q, be_d;
   logic        done_q, done_d;
   logic        auto_q, auto_d;

   logic [MAX_REGIONS-1:0] en_pad;
   region_t                cur_rgn;

   assign en_pad  = MAX_REGIONS'(region_en);
   assign cur_rgn = get_region(SRC_TBL, DST_TBL, SIZE_TBL, idx_q[2:0]);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         rem_q   <= '0;
         off_q   <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         be_q    <= '0;
         done_q  <= 1'b0;
         auto_q  <= AUTO_START;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rem_q   <= rem_d;
         off_q   <= off_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         be_q    <= be_d;
         done_q  <= done_d;
         auto_q  <= auto_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rem_d   = rem_q;
      off_d   = off_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      be_d    = be_q;
      done_d  = done_q;
      auto_d  = auto_q;
      case (state_q)
         ST_IDLE: begin
            if (start || auto_q) begin
               state_d = ST_SELECT;
               idx_d   = '0;
               done_d  = 1'b0;
               auto_d  = 1'b0;
            end
         end
         ST_SELECT: begin
            if (idx_q == 4'(NUM_REGIONS)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else if (!en_pad[idx_q[2:0]] || (cur_rgn.size == '0)) begin
               idx_d = idx_q + 4'd1;
            end else begin
               rem_d   = cur_rgn.size;
               off_d   = '0;
               state_d = ST_OPEN;
            end
         end
         ST_OPEN: state_d = ST_LO;
         ST_LO: begin
            if (flash_valid) begin
               lo_d  = flash_data;
               hi_d  = 8'h00;
               rem_d = rem_q - 24'd1;
               if (rem_q == 24'd1) begin
                  be_d    = 2'b01;
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_HI;
               end
            end
         end
         ST_HI: begin
            if (flash_valid) begin
               hi_d    = flash_data;
               rem_d   = rem_q - 24'd1;
               be_d    = 2'b11;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (ram_wr_ack) begin
               off_d   = off_q + 24'd2;
               state_d = (rem_q == '0) ? ST_CLOSE : ST_LO;
            end
         end
         ST_CLOSE: begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_SELECT;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Word outputs are gated to the WRITE state so the port reads zero otherwise.
   always_comb begin
      busy        = (state_q != ST_IDLE) && (state_q != ST_DONE);
      done        = done_q;
      cur_region  = busy ? idx_q[2:0] : 3'd0;
      flash_req   = (state_q == ST_OPEN);
      flash_addr  = (state_q == ST_OPEN) ? cur_rgn.src : 24'd0;
      flash_stop  = (state_q == ST_CLOSE);
      flash_ready = (state_q == ST_LO) || (state_q == ST_HI);
      ram_wr_req  = (state_q == ST_WRITE);
      ram_addr    = ram_wr_req ? (cur_rgn.dst + off_q) : 24'd0;
      ram_data    = ram_wr_req ? {hi_q, lo_q} : 16'd0;
      ram_be      = ram_wr_req ? be_q : 2'b00;
   end

endmodule

`default_nettype wire

// File: tb/tb_flash_region_loader.sv
// ============================================================================
// Module : tb_flash_region_loader
// Brief  : Scoreboard bench for flash_region_loader with a byte-stream flash model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_flash_region_loader;

   typedef struct {
      logic [23:0] a;
      logic [15:0] d;
      logic [1:0]  be;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [2:0]  region_en;
   logic        busy, done, flash_req, flash_stop, flash_ready, ram_wr_req;
   logic [2:0]  cur_region;
   logic [23:0] flash_addr, ram_addr;
   logic        flash_valid, ram_wr_ack;
   logic [7:0]  flash_data;
   logic [15:0] ram_data;
   logic [1:0]  ram_be;

   int errors = 0;
   int checks = 0;
   int n_req  = 0;
   int n_stop = 0;
   int ack_delay = 0;
   bit toggle = 1'b0;

   wr_t         exp_w[$];
   logic [23:0] exp_src[$];
   logic [2:0]  exp_reg[$];

   flash_region_loader #(
      .NUM_REGIONS (3),
      .REGION_SRC  ({24'h03_0000, 24'h02_0000, 24'h01_0000}),
      .REGION_DST  ({24'h77_E000, 24'h72_0000, 24'h70_0000}),
      .REGION_SIZE ({24'd3, 24'd2, 24'd4}),
      .AUTO_START  (1'b1)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .region_en   (region_en),
      .busy        (busy),
      .done        (done),
      .cur_region  (cur_region),
      .flash_req   (flash_req),
      .flash_addr  (flash_addr),
      .flash_stop  (flash_stop),
      .flash_valid (flash_valid),
      .flash_data  (flash_data),
      .flash_ready (flash_ready),
      .ram_wr_req  (ram_wr_req),
      .ram_addr    (ram_addr),
      .ram_data    (ram_data),
      .ram_be      (ram_be),
      .ram_wr_ack  (ram_wr_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Hand-computed words: flash byte = {src[19:16], offset}.
   task automatic push_entry(input int e);
      case (e)
         0: begin
            exp_w.push_back('{24'h70_0000, 16'h1110, 2'b11});
            exp_w.push_back('{24'h70_0002, 16'h1312, 2'b11});
            exp_src.push_back(24'h01_0000);
         end
         1: begin
            exp_w.push_back('{24'h72_0000, 16'h2120, 2'b11});
            exp_src.push_back(24'h02_0000);
         end
         default: begin
            exp_w.push_back('{24'h77_E000, 16'h3130, 2'b11});
            exp_w.push_back('{24'h77_E002, 16'h0032, 2'b01});
            exp_src.push_back(24'h03_0000);
         end
      endcase
      exp_reg.push_back(3'(e));
   endtask

   task automatic new_run();
      exp_w.delete();
      exp_src.delete();
      exp_reg.delete();
      n_req  = 0;
      n_stop = 0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) break;
      end
      chk("done_reached", done, 1'b1);
   endtask

   task automatic end_run(input int k);
      repeat (2) @(negedge clk);
      chk("writes_left", exp_w.size(), 0);
      chk("flash_req_count", n_req, k);
      chk("flash_stop_count", n_stop, k);
      chk("busy_after_done", busy, 1'b0);
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_ctrl"}, {busy, done, cur_region, flash_req, flash_stop, flash_ready, ram_wr_req}, 0);
      chk({name, "_addr"}, {flash_addr, ram_addr}, 0);
      chk({name, "_data"}, {ram_data, ram_be}, 0);
   endtask

   // Flash byte-stream model
   initial begin
      int          ofs;
      logic [23:0] src;
      logic        pend;
      ofs = 0; src = '0; pend = 1'b0;
      flash_valid = 1'b0; flash_data = 8'h00;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            pend = 1'b0; ofs = 0; flash_valid = 1'b0;
         end else begin
            if (pend) ofs++;
            if (flash_req) begin
               src = flash_addr;
               ofs = 0;
            end
            flash_valid = toggle ? ~flash_valid : 1'b1;
            flash_data  = {src[19:16], 4'(ofs)};
            pend        = flash_valid && flash_ready;
         end
      end
   end

   // SD-RAM acknowledge model
   initial begin
      int cnt;
      cnt = 0;
      ram_wr_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            ram_wr_ack = 1'b0; cnt = 0;
         end else if (ram_wr_ack) begin
            ram_wr_ack = 1'b0;
         end else if (ram_wr_req) begin
            if (cnt >= ack_delay) begin
               ram_wr_ack = 1'b1; cnt = 0;
            end else begin
               cnt++;
            end
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      logic prev_req;
      wr_t  prev, w;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (!reset_n) begin
            prev_req = 1'b0;
         end else begin
            if (ram_wr_req) begin
               if (prev_req) begin
                  chk("ram_addr_stable", ram_addr, prev.a);
                  chk("ram_data_stable", ram_data, prev.d);
                  chk("ram_be_stable", ram_be, prev.be);
               end
               chk("ready_in_write", flash_ready, 1'b0);
               if (ram_wr_ack) begin
                  checks++;
                  if (exp_w.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_write: got addr %0h data %0h, expected none", ram_addr, ram_data);
                  end else begin
                     w = exp_w.pop_front();
                     chk("wr_addr", ram_addr, w.a);
                     chk("wr_data", ram_data, w.d);
                     chk("wr_be", ram_be, w.be);
                  end
                  prev_req = 1'b0;
               end else begin
                  prev_req = 1'b1;
                  prev.a = ram_addr; prev.d = ram_data; prev.be = ram_be;
               end
            end else begin
               prev_req = 1'b0;
            end
            if (flash_req) begin
               n_req++;
               checks++;
               if (exp_src.size() == 0 || exp_reg.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_open: got addr %0h region %0d, expected none", flash_addr, cur_region);
               end else begin
                  chk("flash_addr", flash_addr, exp_src.pop_front());
                  chk("cur_region", cur_region, exp_reg.pop_front());
               end
            end
            if (flash_stop) n_stop++;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit hit;
      reset_n = 1'b0; start = 1'b0; region_en = 3'b111;
      repeat (3) @(negedge clk);
      chk_zero("reset");

      // Auto-start run, all entries
      new_run();
      push_entry(0); push_entry(1); push_entry(2);
      reset_n = 1'b1;
      wait_done(300);
      end_run(3);

      // Entry 1 masked; extra start while busy is ignored
      new_run();
      region_en = 3'b101;
      push_entry(0); push_entry(2);
      pulse_start();
      chk("done_falls", {done, busy}, 2'b01);
      repeat (3) @(negedge clk);
      pulse_start();
      wait_done(300);
      end_run(2);
      repeat (20) @(negedge clk);
      chk("no_rerun", n_req, 2);
      chk("done_held", done, 1'b1);

      // Slow acks and bursty flash
      new_run();
      region_en = 3'b111;
      ack_delay = 5;
      toggle    = 1'b1;
      push_entry(0); push_entry(1); push_entry(2);
      pulse_start();
      wait_done(1000);
      end_run(3);
      ack_delay = 0;
      toggle    = 1'b0;

      // Reset in the middle of entry 1, then auto rerun
      new_run();
      push_entry(0); push_entry(1); push_entry(2);
      pulse_start();
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (busy && cur_region == 3'd1 && ram_wr_req) begin
            hit = 1'b1;
            break;
         end
      end
      chk("reached_region1", hit, 1'b1);
      reset_n = 1'b0;
      new_run();
      @(negedge clk);
      chk_zero("midrun_reset");
      push_entry(0); push_entry(1); push_entry(2);
      reset_n = 1'b1;
      wait_done(300);
      end_run(3);

      // Start after done gives an identical run
      new_run();
      push_entry(0); push_entry(1); push_entry(2);
      pulse_start();
      chk("done_falls2", {done, busy}, 2'b01);
      wait_done(300);
      end_run(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
